// File: rtl/multi_debounce.sv
// Multi-channel input synchroniser and debouncer with registered rise/fall strobes.
// Each channel's output follows its synchronised input only after STABLE_CYCLES consecutive mismatches.
module multi_debounce #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned COUNT_WIDTH   = 16,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] signalIn,
    output logic [CHANNELS-1:0] signalOut,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    localparam logic [COUNT_WIDTH-1:0] TERMINAL = COUNT_WIDTH'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1 || 64'(STABLE_CYCLES) > (64'd1 << COUNT_WIDTH)) begin : g_bad_stable
        $error("multi_debounce: STABLE_CYCLES must lie in 1 .. 2**COUNT_WIDTH");
    end

    logic [CHANNELS-1:0]    sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]    sync;
    logic [COUNT_WIDTH-1:0] cnt_q  [CHANNELS];
    logic [COUNT_WIDTH-1:0] cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]    out_d;
    logic [CHANNELS-1:0]    rise_d;
    logic [CHANNELS-1:0]    fall_d;

    // Synchroniser chain runs independently of enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {CHANNELS{RESET_LEVEL}};
            end
        end else begin
            sync_q[0] <= signalIn;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Per channel: match clears the count, terminal count flips the output and fires a strobe.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = signalOut;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!enable || (sync[i] == signalOut[i])) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == TERMINAL) begin
                cnt_d[i]  = '0;
                out_d[i]  = sync[i];
                rise_d[i] = sync[i];
                fall_d[i] = ~sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            signalOut  <= {CHANNELS{RESET_LEVEL}};
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            cnt_q      <= cnt_d;
            signalOut  <= out_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
        end
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural run-length model.
module tb_multi_debounce;

    localparam int unsigned CH     = 4;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned STABLE = 4;
    localparam int unsigned CW     = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          en_d;
    logic [CH-1:0] sig_in;
    logic [CH-1:0] sig_out, rise, fall;
    logic [CH-1:0] d_out, d_rise, d_fall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_debounce #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .COUNT_WIDTH(CW),
        .STABLE_CYCLES(STABLE), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .signalIn(sig_in),
        .signalOut(sig_out), .rise_pulse(rise), .fall_pulse(fall)
    );

    multi_debounce #(
        .CHANNELS(CH), .SYNC_STAGES(1), .COUNT_WIDTH(CW),
        .STABLE_CYCLES(1), .RESET_LEVEL(1'b0)
    ) dut_deg (
        .clk(clk), .rst_n(rst_n), .enable(en_d), .signalIn(sig_in),
        .signalOut(d_out), .rise_pulse(d_rise), .fall_pulse(d_fall)
    );

    // Reference: input delayed SYNC edges, output flips after STABLE consecutive enabled mismatches.
    logic [CH-1:0] m_hist [SYNC];
    logic [CH-1:0] m_out, m_rise, m_fall;
    int            m_run [CH];
    logic          m_seen;
    logic [CH-1:0] md_s, md_out, md_rise, md_fall;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
            m_out = '0; m_rise = '0; m_fall = '0;
            md_s = '0; md_out = '0; md_rise = '0; md_fall = '0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < CH; c++) begin
                m_seen = m_hist[SYNC-1][c];
                if (!enable || (m_seen == m_out[c])) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == STABLE) begin
                        m_out[c] = m_seen;
                        m_run[c] = 0;
                        if (m_seen) m_rise[c] = 1'b1;
                        else        m_fall[c] = 1'b1;
                    end
                end
            end
            for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = sig_in;
            md_rise = md_s & ~md_out;
            md_fall = ~md_s & md_out;
            md_out  = md_s;
            md_s    = sig_in;
        end
    end

    logic [CH-1:0] seen_rise;
    int            rise_cnt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("out", 32'(sig_out), 32'(m_out));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("rise_fall_excl", 32'(rise & fall), 32'h0);
        chk("deg_out", 32'(d_out), 32'(md_out));
        chk("deg_rise", 32'(d_rise), 32'(md_rise));
        chk("deg_fall", 32'(d_fall), 32'(md_fall));
        seen_rise = seen_rise | rise;
        if (rise[1]) rise_cnt1++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until channel ch reaches lvl or the budget runs out; returns ticks taken.
    task automatic wait_out(input int ch, input logic lvl, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sig_out[ch] !== lvl && n < budget);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        sig_in = '0;
        tick();
        rst_n = 1'b1;
        ticks(2);
    endtask

    int n;

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        en_d      = 1'b1;
        sig_in    = 4'hF;
        seen_rise = '0;
        rise_cnt1 = 0;

        // Power-up: reset dominates a high input, then all channels rise together.
        ticks(3);
        chk("rst_out", 32'(sig_out), 32'h0);
        chk("rst_pulses", 32'(rise | fall), 32'h0);
        rst_n = 1'b1;
        wait_out(0, 1'b1, 20, n);
        chk("pwrup_latency", 32'(n), 32'(1 + SYNC - 1 + STABLE));
        chk("pwrup_out", 32'(sig_out), 32'hF);
        chk("pwrup_rise", 32'(rise), 32'hF);
        tick();
        chk("pwrup_rise_clear", 32'(rise), 32'h0);

        // Glitch shorter than the window is rejected.
        do_reset();
        seen_rise = '0;
        sig_in[0] = 1'b1;
        ticks(3);
        sig_in[0] = 1'b0;
        ticks(8);
        chk("glitch_out", 32'(sig_out[0]), 32'h0);
        chk("glitch_no_rise", 32'(seen_rise[0]), 32'h0);

        // Bounce restarts the window; exactly one rise afterwards.
        rise_cnt1 = 0;
        sig_in[1] = 1'b1; tick();
        sig_in[1] = 1'b0; tick();
        sig_in[1] = 1'b1; tick();
        sig_in[1] = 1'b0; tick();
        sig_in[1] = 1'b1;
        wait_out(1, 1'b1, 20, n);
        chk("bounce_latency", 32'(n), 32'(1 + SYNC - 1 + STABLE));
        ticks(3);
        chk("bounce_one_rise", 32'(rise_cnt1), 32'h1);

        // Simultaneous transitions on two channels.
        sig_in = 4'b0100;
        wait_out(2, 1'b1, 20, n);
        ticks(2);
        chk("simul_start", 32'(sig_out), 32'b0100);
        sig_in = 4'b1000;
        wait_out(3, 1'b1, 20, n);
        chk("simul_out", 32'(sig_out), 32'b1000);
        chk("simul_fall", 32'(fall), 32'b0100);
        chk("simul_rise", 32'(rise), 32'b1000);

        // Enable gating discards a partial count.
        do_reset();
        sig_in = 4'b0001;
        ticks(4);
        enable = 1'b0;
        ticks(3);
        chk("gate_hold", 32'(sig_out[0]), 32'h0);
        enable = 1'b1;
        wait_out(0, 1'b1, 20, n);
        chk("gate_latency", 32'(n), 32'(STABLE));

        // Random traffic with occasional enable drops and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) sig_in = CH'($urandom);
            enable = ($urandom_range(0, 15) != 0);
            rst_n  = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
